uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
Parametrised UART core for the Amber system, succeeding the fixed 8N1, 16-entry UART. It provides a transmit path and a receive path, each with a configurable-depth FIFO. Baud divisor, data length (5-8 bits), parity mode and stop-bit count are selected at runtime. It has sticky error flags and CTS/RTS flow control. A Wishbone register shell instantiates it; the core itself uses a simple push/pop byte interface.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; must be a power of 2 and at least 4
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width
DIV_WIDTH, 16, baud divisor width
RTS_THRESH, FIFO_DEPTH-2, RX count at or above which o_uart_rts_n is deasserted (driven high)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous reset, active low
i_baud_div  in  DIV_WIDTH  clocks per bit minus 1; minimum supported value is 3
i_data_bits  in  2  data length: 0=5 bits, 1=6, 2=7, 3=8
i_parity_en  in  1  1 = append/check a parity bit
i_parity_odd  in  1  1 = odd parity, 0 = even parity
i_two_stop  in  1  1 = two stop bits on TX
i_tx_data  in  8  byte to transmit
i_tx_push  in  1  push i_tx_data into the TX FIFO
o_tx_full  out  1  TX FIFO full
o_tx_empty  out  1  TX FIFO empty
o_tx_count  out  FIFO_AW+1  number of TX FIFO entries
o_tx_busy  out  1  a frame is being transmitted
o_rx_data  out  8  RX FIFO head, show-ahead; upper unused bits are 0
i_rx_pop  in  1  pop the RX FIFO head
o_rx_empty  out  1  RX FIFO empty
o_rx_full  out  1  RX FIFO full
o_rx_count  out  FIFO_AW+1  number of RX FIFO entries
o_parity_err  out  1  sticky parity error
o_frame_err  out  1  sticky framing error
o_overrun  out  1  sticky overrun error
i_err_clr  in  1  clear all three sticky error flags
o_uart_txd  out  1  serial transmit output
i_uart_rxd  in  1  serial receive input, asynchronous
i_uart_cts_n  in  1  clear-to-send, active low, asynchronous
o_uart_rts_n  out  1  request-to-send, active low

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - FIFOs flushed; counts 0; empty flags 1, full flags 0.
  - o_uart_txd=1, o_tx_busy=0, o_uart_rts_n=0, all error flags 0, o_rx_data=0.
  - Both FSMs go to IDLE, aborting any frame in progress; TXD returns high on the next cycle.
- FIFOs:
  - A push when full is ignored, even if a pop occurs in the same cycle. A pop when empty is ignored.
  - A simultaneous push and pop when neither full nor empty leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is registered.
- Synchronisers: i_uart_rxd and i_uart_cts_n each pass through 2 flip-flops (reset value 1) before use.
- Bit period: every serial bit lasts i_baud_div+1 clocks, timed by one down-counter per FSM.
- Frame configuration: on leaving IDLE, each FSM latches the baud divisor, data length, parity and stop settings. Changes during a frame take effect on the next frame.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE -> START when the TX FIFO is not empty and synced CTS is low. The head is popped into the shift register on that transition.
  - START drives 0. DATA sends the data bits LSB first.
  - PARITY is entered only if parity is enabled. The bit is the XOR of the data bits, inverted for odd parity.
  - STOP drives 1 for 1 or 2 bit periods.
  - o_tx_busy=1 in every state except IDLE.
  - Frames may go back-to-back: STOP -> START directly if the FIFO is not empty and CTS is low.
  - CTS is checked only at frame start; deasserting CTS mid-frame does not abort the frame.
- RX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE -> START on a synced 1-to-0 transition.
  - START waits floor(i_baud_div/2) clocks, then samples. If the line is high, return to IDLE with no error (false start).
  - Data bits are sampled every i_baud_div+1 clocks, LSB first, and zero-extended to 8 bits.
  - PARITY (if enabled): a mismatch sets o_parity_err.
  - STOP: one stop bit is sampled regardless of i_two_stop. A value of 0 sets o_frame_err.
  - After the stop sample the FSM goes to IDLE immediately. The byte is pushed even if an error was flagged.
  - If the RX FIFO is full at push time, the byte is dropped and o_overrun is set. FIFO contents are unchanged.
- Error flags:
  - Sticky until i_err_clr is asserted.
  - If clear and set occur in the same cycle, set wins.
- RTS: o_uart_rts_n = (o_rx_count >= RTS_THRESH), registered.

Test Plan:
- div=3, 8N1, push 0xA5 -> TXD is 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; o_tx_busy high for 40 clocks; o_tx_empty=1 after the pop.
- Loopback (rxd=txd), div=3, 7 data bits, odd parity, push 0x55 -> parity bit=1; RX receives 0x55; o_parity_err=0.
- cts_n=1, push 17 bytes 0x00..0x10 -> o_tx_count=16, full=1, 0x10 dropped, TXD idle. Then cts_n=0 -> 16 frames sent in order 0x00..0x0F.
- Drive 17 valid frames into RX with no pops -> o_rx_count=16, o_overrun=1, o_rts_n=1 from count 14, head=first byte. Pulse i_err_clr -> o_overrun=0.
- RX with stop bit forced 0 -> o_frame_err=1 and the byte is stored. A 2-clock low glitch with div=7 -> no byte stored and no error.
- Reset asserted mid-TX-frame (during DATA bit 3) -> next cycle TXD=1, busy=0, counts 0; a subsequent push transmits normally.

Source files
------------

// File: rtl/uart_core_param.sv
// Parametrised UART core: runtime frame format, push/pop byte FIFOs, sticky errors, CTS/RTS.
// Also holds the generic FIFO that both directions use.

// Generic show-ahead FIFO.
// Latency: a pushed entry appears at the head one cycle later; count is registered.
// Backpressure: push ignored when full (even with a same-cycle pop), pop ignored when empty.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  // Head reads as zero while empty so the byte port is clean after reset.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// UART core with independent TX and RX serialisers.
// Latency: TX frame starts two cycles after a push; RX byte is pushed mid stop bit plus 3 sync cycles.
// Backpressure: TX holds frames while CTS is high; RX drops bytes into a full FIFO and flags overrun.
module uart_core_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH),
  parameter int DIV_WIDTH  = 16,
  parameter int RTS_THRESH = FIFO_DEPTH - 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DIV_WIDTH-1:0] i_baud_div,
  input  logic [1:0]           i_data_bits,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  input  logic [7:0]           i_tx_data,
  input  logic                 i_tx_push,
  output logic                 o_tx_full,
  output logic                 o_tx_empty,
  output logic [FIFO_AW:0]     o_tx_count,
  output logic                 o_tx_busy,
  output logic [7:0]           o_rx_data,
  input  logic                 i_rx_pop,
  output logic                 o_rx_empty,
  output logic                 o_rx_full,
  output logic [FIFO_AW:0]     o_rx_count,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  input  logic                 i_err_clr,
  output logic                 o_uart_txd,
  input  logic                 i_uart_rxd,
  input  logic                 i_uart_cts_n,
  output logic                 o_uart_rts_n
);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

  localparam logic [FIFO_AW:0] RTS_TH = RTS_THRESH[FIFO_AW:0];

  function automatic logic [7:0] data_mask(input logic [1:0] code);
    case (code)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] last_bit(input logic [1:0] code);
    last_bit = 3'd4 + {1'b0, code};
  endfunction

  // Two-flop synchronisers; rxd_prev gives the falling-edge detector its history.
  logic rxd_s1, rxd_s2, rxd_prev, cts_s1, cts_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      cts_s1   <= 1'b1;
      cts_s2   <= 1'b1;
    end else begin
      rxd_s1   <= i_uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      cts_s1   <= i_uart_cts_n;
      cts_s2   <= cts_s1;
    end
  end

  logic [7:0] tx_head_dat;
  logic       tx_pop;
  logic       rx_push;
  logic [7:0] rx_data, rx_data_nxt;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(8)) u_tx_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push_vld (i_tx_push),
    .push_dat (i_tx_data),
    .pop_rdy  (tx_pop),
    .head_dat (tx_head_dat),
    .count    (o_tx_count),
    .full     (o_tx_full),
    .empty    (o_tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(8)) u_rx_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push_vld (rx_push),
    .push_dat (rx_data),
    .pop_rdy  (i_rx_pop),
    .head_dat (o_rx_data),
    .count    (o_rx_count),
    .full     (o_rx_full),
    .empty    (o_rx_empty)
  );

  // ---------------- transmitter ----------------
  uart_state_t          tx_state, tx_state_nxt;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_nxt, tx_div, tx_div_nxt;
  logic [1:0]           tx_code, tx_code_nxt;
  logic                 tx_pen, tx_pen_nxt, tx_two, tx_two_nxt;
  logic                 tx_par, tx_par_nxt, tx_stop2, tx_stop2_nxt;
  logic [7:0]           tx_shift, tx_shift_nxt;
  logic [2:0]           tx_bit, tx_bit_nxt;
  logic                 tx_go, tx_load, tx_txd;
  logic [7:0]           tx_head_masked;

  always_comb begin
    tx_state_nxt   = tx_state;
    tx_cnt_nxt     = tx_cnt;
    tx_div_nxt     = tx_div;
    tx_code_nxt    = tx_code;
    tx_pen_nxt     = tx_pen;
    tx_two_nxt     = tx_two;
    tx_par_nxt     = tx_par;
    tx_stop2_nxt   = tx_stop2;
    tx_shift_nxt   = tx_shift;
    tx_bit_nxt     = tx_bit;
    tx_load        = 1'b0;
    tx_txd         = 1'b1;
    tx_go          = !o_tx_empty && !cts_s2;
    tx_head_masked = tx_head_dat & data_mask(i_data_bits);

    case (tx_state)
      ST_IDLE: tx_load = tx_go;
      default: begin
        if (tx_cnt != '0) begin
          tx_cnt_nxt = tx_cnt - 1'b1;
        end else begin
          tx_cnt_nxt = tx_div;
          case (tx_state)
            ST_START: begin
              tx_state_nxt = ST_DATA;
              tx_bit_nxt   = '0;
            end
            ST_DATA: begin
              tx_shift_nxt = tx_shift >> 1;
              tx_bit_nxt   = tx_bit + 1'b1;
              if (tx_bit == last_bit(tx_code)) begin
                tx_state_nxt = tx_pen ? ST_PARITY : ST_STOP;
                tx_stop2_nxt = 1'b0;
              end
            end
            ST_PARITY: begin
              tx_state_nxt = ST_STOP;
              tx_stop2_nxt = 1'b0;
            end
            default: begin
              // End of a stop period: second stop bit, back-to-back frame, or idle.
              if (tx_two && !tx_stop2) tx_stop2_nxt = 1'b1;
              else if (tx_go)          tx_load      = 1'b1;
              else                     tx_state_nxt = ST_IDLE;
            end
          endcase
        end
      end
    endcase

    if (tx_load) begin
      tx_state_nxt = ST_START;
      tx_cnt_nxt   = i_baud_div;
      tx_div_nxt   = i_baud_div;
      tx_code_nxt  = i_data_bits;
      tx_pen_nxt   = i_parity_en;
      tx_two_nxt   = i_two_stop;
      tx_shift_nxt = tx_head_masked;
      tx_par_nxt   = (^tx_head_masked) ^ i_parity_odd;
      tx_stop2_nxt = 1'b0;
    end

    case (tx_state)
      ST_START:  tx_txd = 1'b0;
      ST_DATA:   tx_txd = tx_shift[0];
      ST_PARITY: tx_txd = tx_par;
      default:   tx_txd = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_code  <= '0;
      tx_pen   <= 1'b0;
      tx_two   <= 1'b0;
      tx_par   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_div   <= tx_div_nxt;
      tx_code  <= tx_code_nxt;
      tx_pen   <= tx_pen_nxt;
      tx_two   <= tx_two_nxt;
      tx_par   <= tx_par_nxt;
      tx_stop2 <= tx_stop2_nxt;
      tx_shift <= tx_shift_nxt;
      tx_bit   <= tx_bit_nxt;
    end
  end

  assign tx_pop     = tx_load;
  assign o_uart_txd = tx_txd;
  assign o_tx_busy  = (tx_state != ST_IDLE);

  // ---------------- receiver ----------------
  uart_state_t          rx_state, rx_state_nxt;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_nxt, rx_div, rx_div_nxt;
  logic [1:0]           rx_code, rx_code_nxt;
  logic                 rx_pen, rx_pen_nxt, rx_podd, rx_podd_nxt;
  logic [2:0]           rx_bit, rx_bit_nxt;
  logic                 par_set, frame_set, overrun_set;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_div_nxt   = rx_div;
    rx_code_nxt  = rx_code;
    rx_pen_nxt   = rx_pen;
    rx_podd_nxt  = rx_podd;
    rx_data_nxt  = rx_data;
    rx_bit_nxt   = rx_bit;
    rx_push      = 1'b0;
    par_set      = 1'b0;
    frame_set    = 1'b0;

    case (rx_state)
      ST_IDLE: begin
        if (rxd_prev && !rxd_s2) begin
          // Half-period wait puts every later sample near the bit centre.
          rx_state_nxt = ST_START;
          rx_cnt_nxt   = i_baud_div >> 1;
          rx_div_nxt   = i_baud_div;
          rx_code_nxt  = i_data_bits;
          rx_pen_nxt   = i_parity_en;
          rx_podd_nxt  = i_parity_odd;
          rx_data_nxt  = '0;
          rx_bit_nxt   = '0;
        end
      end
      default: begin
        if (rx_cnt != '0) begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end else begin
          rx_cnt_nxt = rx_div;
          case (rx_state)
            ST_START: rx_state_nxt = rxd_s2 ? ST_IDLE : ST_DATA;
            ST_DATA: begin
              rx_data_nxt[rx_bit] = rxd_s2;
              rx_bit_nxt          = rx_bit + 1'b1;
              if (rx_bit == last_bit(rx_code))
                rx_state_nxt = rx_pen ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
              par_set      = (rxd_s2 != ((^rx_data) ^ rx_podd));
              rx_state_nxt = ST_STOP;
            end
            default: begin
              frame_set    = !rxd_s2;
              rx_push      = 1'b1;
              rx_state_nxt = ST_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_code  <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_data  <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_div   <= rx_div_nxt;
      rx_code  <= rx_code_nxt;
      rx_pen   <= rx_pen_nxt;
      rx_podd  <= rx_podd_nxt;
      rx_data  <= rx_data_nxt;
      rx_bit   <= rx_bit_nxt;
    end
  end

  assign overrun_set = rx_push && o_rx_full;

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_uart_rts_n <= 1'b0;
    end else begin
      o_parity_err <= par_set     || (o_parity_err && !i_err_clr);
      o_frame_err  <= frame_set   || (o_frame_err  && !i_err_clr);
      o_overrun    <= overrun_set || (o_overrun    && !i_err_clr);
      o_uart_rts_n <= (o_rx_count >= RTS_TH);
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: table and random loopback frames against a frame model,
// plus flow-control, overrun, error, glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_core_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, two_stop;
  logic [7:0]  tx_data;
  logic        tx_push;
  logic        tx_full, tx_empty, tx_busy;
  logic [4:0]  tx_count, rx_count;
  logic [7:0]  rx_data;
  logic        rx_pop, rx_empty, rx_full;
  logic        perr, ferr, ovr, err_clr;
  logic        txd, rxd, cts_n, rts_n;
  logic        loop_en, rxd_drv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign rxd = loop_en ? txd : rxd_drv;

  uart_core_param dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_baud_div(baud_div), .i_data_bits(data_bits),
    .i_parity_en(parity_en), .i_parity_odd(parity_odd), .i_two_stop(two_stop),
    .i_tx_data(tx_data), .i_tx_push(tx_push), .o_tx_full(tx_full), .o_tx_empty(tx_empty),
    .o_tx_count(tx_count), .o_tx_busy(tx_busy), .o_rx_data(rx_data), .i_rx_pop(rx_pop),
    .o_rx_empty(rx_empty), .o_rx_full(rx_full), .o_rx_count(rx_count),
    .o_parity_err(perr), .o_frame_err(ferr), .o_overrun(ovr), .i_err_clr(err_clr),
    .o_uart_txd(txd), .i_uart_rxd(rxd), .i_uart_cts_n(cts_n), .o_uart_rts_n(rts_n)
  );

  typedef struct {
    logic [7:0] dat;
    logic [1:0] code;
    logic       pen;
    logic       podd;
    logic       two;
    int         div;
    logic       exp_par;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference rules: an N-bit word keeps its low N bits; parity is the ones-count parity, flipped for odd.
  function automatic logic [7:0] m_mask(input logic [1:0] code);
    int nb;
    nb = 5 + int'(code);
    return 8'((1 << nb) - 1);
  endfunction

  function automatic logic m_par(input logic [7:0] b, input logic [1:0] code, input logic podd);
    return ((($countones(b & m_mask(code)) % 2) == 1) ? 1'b1 : 1'b0) ^ podd;
  endfunction

  task automatic set_cfg(input int div, input logic [1:0] code, input logic pen, input logic podd,
                         input logic two);
    baud_div   = 16'(div);
    data_bits  = code;
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = two;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Records TXD every cycle while busy and compares it with the expected bit list.
  task automatic check_tx_frame(input string tag, input logic [7:0] b, input logic [1:0] code,
                                input logic pen, input logic podd, input logic two, input int div,
                                output logic par_seen);
    logic eb[$];
    int   n, errs, per, w;
    per = div + 1;
    eb.push_back(1'b0);
    for (int i = 0; i < 5 + int'(code); i++) eb.push_back(b[i]);
    if (pen) eb.push_back(m_par(b, code, podd));
    eb.push_back(1'b1);
    if (two) eb.push_back(1'b1);
    w = 0;
    while (!tx_busy && w < 500) begin
      tick();
      w++;
    end
    chk({tag, "_start"}, 32'(tx_busy), 32'd1);
    n = 0;
    errs = 0;
    par_seen = 1'b0;
    while (tx_busy && n < 2000) begin
      if (n / per < eb.size()) begin
        if (txd !== eb[n / per]) errs++;
      end else begin
        errs++;
      end
      if (pen && n == (6 + int'(code)) * per + per / 2) par_seen = txd;
      tick();
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'(eb.size() * per));
    chk({tag, "_bits"}, 32'(errs), 32'd0);
  endtask

  task automatic run_loopback(input string tag, input logic [7:0] b, input logic [1:0] code,
                              input logic pen, input logic podd, input logic two, input int div,
                              input logic exp_par, input logic [7:0] exp_rx);
    logic ps;
    int   w;
    set_cfg(div, code, pen, podd, two);
    loop_en = 1'b1;
    push_tx(b);
    check_tx_frame(tag, b, code, pen, podd, two, div, ps);
    if (pen) chk({tag, "_par"}, 32'(ps), 32'(exp_par));
    chk({tag, "_txempty"}, 32'(tx_empty), 32'd1);
    w = 0;
    while (rx_empty && w < 300) begin
      tick();
      w++;
    end
    chk({tag, "_rxdat"}, 32'(rx_data), 32'(exp_rx));
    chk({tag, "_errs"}, 32'({perr, ferr, ovr}), 32'd0);
    pop_rx();
    chk({tag, "_rxempty"}, 32'(rx_empty), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic [1:0] code, input logic pen,
                         input logic podd, input logic pflip, input logic stopv, input int div);
    int per;
    per = div + 1;
    rxd_drv = 1'b0;
    tick(per);
    for (int i = 0; i < 5 + int'(code); i++) begin
      rxd_drv = b[i];
      tick(per);
    end
    if (pen) begin
      rxd_drv = m_par(b, code, podd) ^ pflip;
      tick(per);
    end
    rxd_drv = stopv;
    tick(per);
    rxd_drv = 1'b1;
    tick(2 * per);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [6];
    logic [7:0] mq [$];
    logic [7:0] b, exp_b;
    logic       ps;
    int         w, lowcnt;

    vt[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'hA5};
    vt[1] = '{8'h55, 2'd2, 1'b1, 1'b1, 1'b0, 3, 1'b1, 8'h55};
    vt[2] = '{8'hFF, 2'd0, 1'b1, 1'b0, 1'b0, 5, 1'b1, 8'h1F};
    vt[3] = '{8'h3C, 2'd1, 1'b1, 1'b1, 1'b1, 4, 1'b1, 8'h3C};
    vt[4] = '{8'h80, 2'd2, 1'b1, 1'b0, 1'b0, 6, 1'b0, 8'h00};
    vt[5] = '{8'h96, 2'd3, 1'b1, 1'b1, 1'b1, 3, 1'b1, 8'h96};

    rst_n = 1'b0; tx_push = 1'b0; tx_data = '0; rx_pop = 1'b0; err_clr = 1'b0;
    cts_n = 1'b0; loop_en = 1'b0; rxd_drv = 1'b1;
    set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    tick(3);

    chk("rst_txd_busy", 32'({txd, tx_busy}), 32'b10);
    chk("rst_empty", 32'({tx_empty, rx_empty}), 32'b11);
    chk("rst_full", 32'({tx_full, rx_full}), 32'b00);
    chk("rst_counts", 32'({tx_count, rx_count}), 32'd0);
    chk("rst_rts_errs", 32'({rts_n, perr, ferr, ovr}), 32'd0);
    chk("rst_rxdata", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 6; i++)
      run_loopback($sformatf("vec%0d", i), vt[i].dat, vt[i].code, vt[i].pen, vt[i].podd,
                   vt[i].two, vt[i].div, vt[i].exp_par, vt[i].exp_rx);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] c;
      logic       pe, po, ts;
      int         d;
      b  = 8'($urandom);
      c  = 2'($urandom_range(0, 3));
      pe = 1'($urandom);
      po = 1'($urandom);
      ts = 1'($urandom);
      d  = $urandom_range(3, 6);
      run_loopback($sformatf("rnd%0d", i), b, c, pe, po, ts, d, m_par(b, c, po), b & m_mask(c));
    end

    // CTS held off: FIFO fills, 17th byte dropped, line stays idle.
    cts_n = 1'b1;
    set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    loop_en = 1'b1;
    tick(3);
    for (int i = 0; i < 17; i++) push_tx(8'(i));
    chk("cts_txcount", 32'(tx_count), 32'd16);
    chk("cts_txfull", 32'(tx_full), 32'd1);
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!txd || tx_busy) lowcnt++;
      tick();
    end
    chk("cts_idle", 32'(lowcnt), 32'd0);
    cts_n = 1'b0;
    w = 0;
    while (rx_count != 5'd16 && w < 1500) begin
      tick();
      w++;
    end
    tick(60);
    chk("cts_rxcount", 32'(rx_count), 32'd16);
    chk("cts_rts_full", 32'({rts_n, rx_full}), 32'b11);
    chk("cts_tx_done", 32'({tx_empty, tx_busy, ovr}), 32'b100);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("cts_order%0d", i), 32'(rx_data), 32'(i));
      pop_rx();
    end
    tick(2);
    chk("cts_drained", 32'({rx_empty, rts_n}), 32'b10);

    // RX overrun with random bytes; RTS follows the count threshold.
    loop_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_rx(b, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      if (mq.size() < 16) mq.push_back(b);
      chk($sformatf("ovr_count%0d", i), 32'(rx_count), 32'(mq.size()));
      chk($sformatf("ovr_rts%0d", i), 32'(rts_n), 32'(mq.size() >= 14));
    end
    chk("ovr_flag", 32'({ovr, rx_full}), 32'b11);
    chk("ovr_head", 32'(rx_data), 32'(mq[0]));
    clr_err();
    chk("ovr_clr", 32'(ovr), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_b = mq.pop_front();
      chk($sformatf("ovr_data%0d", i), 32'(rx_data), 32'(exp_b));
      pop_rx();
    end

    // Stop bit forced low: framing error, byte still stored.
    send_rx(8'h3A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("ferr_flag", 32'({perr, ferr}), 32'b01);
    chk("ferr_stored", 32'({rx_count, rx_data}), 32'({5'd1, 8'h3A}));
    pop_rx();
    clr_err();
    chk("ferr_clr", 32'(ferr), 32'd0);

    // Corrupted parity bit.
    set_cfg(3, 2'd3, 1'b1, 1'b0, 1'b0);
    send_rx(8'h5B, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    chk("perr_flag", 32'({perr, ferr}), 32'b10);
    chk("perr_data", 32'(rx_data), 32'h5B);
    pop_rx();
    clr_err();

    // Short low glitch is a false start.
    set_cfg(7, 2'd3, 1'b0, 1'b0, 1'b0);
    rxd_drv = 1'b0;
    tick(2);
    rxd_drv = 1'b1;
    tick(40);
    chk("glitch_count", 32'(rx_count), 32'd0);
    chk("glitch_errs", 32'({perr, ferr, ovr}), 32'd0);

    // Reset during data bit 3 of a frame.
    set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    push_tx(8'hA5);
    w = 0;
    while (!tx_busy && w < 50) begin
      tick();
      w++;
    end
    push_tx(8'h11);
    push_tx(8'h22);
    tick(15);
    chk("mid_bit3", 32'({tx_busy, txd}), 32'b10);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_line", 32'({txd, tx_busy}), 32'b10);
    chk("mid_rst_counts", 32'({tx_count, rx_count}), 32'd0);
    rst_n = 1'b1;
    tick(3);
    run_loopback("post_rst", 8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
